spi_access_sched: RTL and testbench
===================================

# spi_access_sched

Round-robin scheduler that shares the single SPI-access interrupt path (arm/go pair into the SPI access interrupt generator) between `NREQ` on-board requesters such as the host command decoder and the HV/maroc config loader. It grants one requester at a time and drives `arm`, then a one-cycle `go`. It waits for the processor's completion acknowledge or a timeout, releases `arm`, and returns a per-requester done pulse with status.

## Interface
- `NREQ`, default 2: number of requesters (2..8).
- `ARM_SETUP`, default 16: cycles `arm` is held before `go` is pulsed (≥1).
- `TIMEOUT`, default 100000: cycles to wait for `spi_ack` after `go`; 1 ms at 100 MHz.
- `HOLDOFF`, default 8: cycles `arm` stays low after release before the next grant (≥1).
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: level request per requester; held until its `done` bit pulses.
- `gnt` out NREQ: one-hot grant; at most one bit set.
- `done` out NREQ: one-cycle completion pulse to the granted requester.
- `err` out 1: status qualifying `done`; 0 means ack received, 1 means timeout or abort. Valid only in the `done` cycle.
- `arm` out 1: arm to the SPI access interrupt generator.
- `go` out 1: one-cycle go pulse to the interrupt generator.
- `spi_ack` in 1: processor completion flag (level); its rising edge is used.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, ARM, GO, WAIT, RELEASE.
- **IDLE:** if any `req` bit is set, pick the winner round-robin, searching upward from `ptr` with wrap-around, then go to ARM. Set `gnt[w]`, `arm`=1 and `ptr` = w+1 mod NREQ.
- **ARM:** count `ARM_SETUP` cycles with `arm`=1, then go to GO.
- **GO:** `go`=1 for exactly one cycle, `arm` stays 1, then go to WAIT with the counter cleared.
- **WAIT:** `arm`=1 and the counter increments every cycle.
  - Rising edge of `spi_ack` (registered `spi_ack_d1`): go to RELEASE with status 0.
  - Counter reaches `TIMEOUT`-1: go to RELEASE with status 1.
- **RELEASE:** `arm`=0.
  - First cycle: `done[w]`=1 and `err`=status.
  - Hold for `HOLDOFF` cycles, then go to IDLE.
  - `gnt[w]` drops when IDLE is entered.
- **Abort:** if `req[w]` falls in ARM, GO or WAIT, go to RELEASE with status 1. A `go` already issued is not retracted.
- **Simultaneous events:**
  - Ack and timeout in the same cycle: ack wins and `err`=0.
  - Ack during ARM or GO: ignored. The edge detector still updates, so a level held high does not trigger in WAIT.
  - Abort in the same cycle as ack: ack wins.
- **Counters:**
  - Wait counter width is $clog2(TIMEOUT+1) and it saturates, never wrapping.
  - Setup and holdoff share one counter of width $clog2(max(ARM_SETUP,HOLDOFF)+1).
- `req` bits for non-granted requesters are ignored until IDLE.

## Timing
- Reset values: `gnt`=0, `done`=0, `err`=0, `arm`=0, `go`=0, `busy`=0, `ptr`=0, state IDLE, all counters 0.
- Reset mid-operation forces these values on the next edge. No `done` pulse is issued for the killed transfer.
- All outputs are registered.
- `req` high in cycle 0 → `gnt` and `arm` high in cycle 1.
- `go` high in cycle 1+`ARM_SETUP`, then low.
- WAIT begins in cycle 2+`ARM_SETUP`.
- `spi_ack` rises in cycle k → `arm`=0 and `done`=1 in cycle k+2 (one cycle for the edge register, one for the state register).
- Minimum request-to-request spacing for back-to-back grants is `ARM_SETUP`+`HOLDOFF`+4 cycles.

## Structure
- Package `spi_access_pkg` holds:
  - the state enum (IDLE, ARM, GO, WAIT, RELEASE);
  - status constants `ST_OK`=0 and `ST_FAIL`=1;
  - default `TIMEOUT` constant `SPI_TIMEOUT_1MS`=100000.
- Sub-module `rr_arbiter` (parameter NREQ) takes `req`, `ptr` and an enable. It returns a one-hot winner and the next pointer.
- The FSM and counters live in the top level.

## Test plan
- **Single requester:** `req[0]`=1 with ack 20 cycles after `go` (`ARM_SETUP`=16). Expect `go` in cycle 17, `done[0]` with `err`=0 two cycles after ack, and `arm` low for 8 cycles.
- **Round-robin:** `req[0]` and `req[1]` both held high. Expect grants 0,1,0,1 with no overlap and `gnt` one-hot.
- **Timeout:** `TIMEOUT`=50, no ack. Expect `done` with `err`=1 exactly 50 cycles after WAIT entry and `arm` falling in the same cycle.
- **Boundary:** ack and timeout coincide → `err`=0. Ack held high from before `go` → no ack detected, timeout reported.
- **Abort:** `req[1]` drops in WAIT → RELEASE, `done[1]`=1 with `err`=1, then `req[0]` is granted after holdoff.
- **Reset:** `rst` pulsed in WAIT → all outputs 0 next cycle, no `done` pulse, and the next request is granted to index 0.

Source files
------------

// File: rtl/spi_access_pkg.sv
// Shared types and constants for the SPI-access interrupt scheduler.
package spi_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    GO,
    WAIT,
    RELEASE
  } state_t;

  localparam logic ST_OK   = 1'b0;
  localparam logic ST_FAIL = 1'b1;

  localparam int SPI_TIMEOUT_1MS = 100000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] next_ptr
);

  localparam int          PW = $clog2(NREQ);
  localparam int unsigned N  = NREQ;

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    win      = '0;
    next_ptr = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        next_ptr = PW'((32'(idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/spi_access_sched.sv
// Grants the shared SPI-access interrupt path to one requester at a time:
// arm, one-cycle go, wait for ack or timeout, release, report done/err.
module spi_access_sched
  import spi_access_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ARM_SETUP = 16,
  parameter int TIMEOUT   = SPI_TIMEOUT_1MS,
  parameter int HOLDOFF   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            arm,
  output logic            go,
  input  logic            spi_ack,
  output logic            busy
);

  localparam int PW     = $clog2(NREQ);
  localparam int HS_MAX = (ARM_SETUP > HOLDOFF) ? ARM_SETUP : HOLDOFF;
  localparam int CW     = $clog2(HS_MAX + 1);
  localparam int WW     = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] win;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   wcnt;
  logic            ack_d1, ack_d2;
  logic            ack_rise, granted_live;
  logic            rel, rel_st;

  assign ack_rise     = ack_d1 & ~ack_d2;
  assign granted_live = |(req & gnt);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .en      (state == IDLE),
    .win     (win),
    .next_ptr(next_ptr)
  );

  // Release priority in WAIT: ack beats timeout, which ties with abort on status.
  always_comb begin
    rel    = 1'b0;
    rel_st = ST_FAIL;
    unique case (state)
      ARM, GO: rel = !granted_live;
      WAIT: begin
        if (ack_rise) begin
          rel    = 1'b1;
          rel_st = ST_OK;
        end else if (wcnt == WW'(TIMEOUT - 1) || !granted_live) begin
          rel = 1'b1;
        end
      end
      default: rel = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      arm    <= 1'b0;
      go     <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      wcnt   <= '0;
      ack_d1 <= 1'b0;
      ack_d2 <= 1'b0;
    end else begin
      ack_d1 <= spi_ack;
      ack_d2 <= ack_d1;
      done   <= '0;
      err    <= 1'b0;
      go     <= 1'b0;
      if (rel) begin
        state <= RELEASE;
        arm   <= 1'b0;
        done  <= gnt;
        err   <= rel_st;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (|req) begin
              state <= ARM;
              gnt   <= win;
              arm   <= 1'b1;
              busy  <= 1'b1;
              ptr   <= next_ptr;
              cnt   <= '0;
            end
          end
          ARM: begin
            if (cnt == CW'(ARM_SETUP - 1)) begin
              state <= GO;
              go    <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GO: begin
            state <= WAIT;
            wcnt  <= '0;
          end
          WAIT: wcnt <= (wcnt == '1) ? wcnt : wcnt + 1'b1;
          RELEASE: begin
            if (cnt == CW'(HOLDOFF - 1)) begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_access_sched.sv
// Directed plus randomized transactions against a timestamp-based reference model.
module tb_spi_access_sched;

  localparam int N    = 3;
  localparam int A    = 16;
  localparam int T    = 50;
  localparam int H    = 8;
  localparam int NONE = -1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         err;
  logic         arm;
  logic         go;
  logic         spi_ack;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ptr_m    = 0;

  always #5 clk = ~clk;

  spi_access_sched #(
    .NREQ     (N),
    .ARM_SETUP(A),
    .TIMEOUT  (T),
    .HOLDOFF  (H)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt    (gnt),
    .done   (done),
    .err    (err),
    .arm    (arm),
    .go     (go),
    .spi_ack(spi_ack),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),  32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err),  32'd0);
    chk({tag, "_arm"},  32'(arm),  32'd0);
    chk({tag, "_go"},   32'(go),   32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One transaction: idle request cycle, then cycles up to the last RELEASE
  // cycle (or the cycle after a reset pulse). Offsets are relative to grant.
  task automatic run_txn(input logic [N-1:0] mask, input int ack_k, input int abort_m,
                         input bit keep, input int rst_off);
    int g, w, e, r, last;
    bit e_err;
    tick();
    req     = mask;
    spi_ack = (ack_k == -1);
    rst     = 1'b0;
    @(negedge clk);
    chk("idle_gnt",  32'(gnt),  32'd0);
    chk("idle_arm",  32'(arm),  32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    g     = cyc + 1;
    w     = rr_pick(ptr_m, mask);
    ptr_m = (w + 1) % N;
    e     = g + A + 1 + T;
    e_err = 1'b1;
    if (abort_m != NONE && g + abort_m + 1 < e) e = g + abort_m + 1;
    if (ack_k != NONE && g + ack_k + 1 >= g + A + 1 && g + ack_k + 2 <= e) begin
      e     = g + ack_k + 2;
      e_err = 1'b0;
    end
    r    = (rst_off == NONE) ? NONE : g + rst_off;
    last = (rst_off == NONE) ? e + H - 1 : r + 1;

    for (int c = g; c <= last; c++) begin
      tick();
      if (rst_off != NONE && cyc == r + 1) begin
        rst     = 1'b0;
        req     = '0;
        spi_ack = 1'b0;
        @(negedge clk);
        check_all_zero("rst");
      end else begin
        req = mask;
        if (!keep && cyc > e) req[w] = 1'b0;
        if (abort_m != NONE && cyc >= g + abort_m) req[w] = 1'b0;
        spi_ack = (ack_k != NONE && cyc >= g + ack_k && cyc <= e);
        rst     = (rst_off != NONE && cyc == r);
        @(negedge clk);
        chk("gnt",  32'(gnt),  32'(1) << w);
        chk("arm",  32'(arm),  32'(cyc < e));
        chk("go",   32'(go),   32'(cyc == g + A && e > g + A));
        chk("done", 32'(done), (cyc == e) ? (32'(1) << w) : 32'd0);
        if (cyc == e) chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'd1);
      end
    end
    if (rst_off != NONE) ptr_m = 0;
  endtask

  initial begin
    int mode, ak, ab;
    logic [N-1:0] m;
    rst     = 1'b1;
    req     = '0;
    spi_ack = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single requester, ack 20 cycles after go.
    run_txn(3'b001, A + 20, NONE, 1'b0, NONE);
    // Round-robin with two requesters held high.
    for (int i = 0; i < 4; i++) run_txn(3'b011, A + 3 + i, NONE, 1'b1, NONE);
    // Timeout, ack/timeout tie, ack level held from before go.
    run_txn(3'b001, NONE, NONE, 1'b0, NONE);
    run_txn(3'b001, A + T - 1, NONE, 1'b0, NONE);
    run_txn(3'b001, -1, NONE, 1'b0, NONE);
    // Abort requester 1 in WAIT, then requester 0 follows after holdoff.
    run_txn(3'b001, A + 5, NONE, 1'b0, NONE);
    run_txn(3'b011, NONE, A + 6, 1'b1, NONE);
    run_txn(3'b001, A + 4, NONE, 1'b0, NONE);
    // Abort coinciding with ack: ack wins.
    run_txn(3'b100, A + 7, A + 8, 1'b0, NONE);
    // Reset during WAIT of requester 1; next grant goes to index 0.
    run_txn(3'b001, A + 2, NONE, 1'b0, NONE);
    run_txn(3'b011, NONE, NONE, 1'b1, A + 10);
    run_txn(3'b011, A + 2, NONE, 1'b0, NONE);

    for (int i = 0; i < 30; i++) begin
      m    = 3'($urandom_range(1, 7));
      mode = $urandom_range(0, 3);
      ak   = NONE;
      ab   = NONE;
      case (mode)
        0: ak = $urandom_range(A, A + T + 1);
        1: ak = ($urandom_range(0, 1) == 1) ? -1 : NONE;
        2: begin
          ab = $urandom_range(0, A + T);
          if ($urandom_range(0, 1) == 1) ak = $urandom_range(0, A + T + 3) - 1;
        end
        default: ak = $urandom_range(0, A) - 1;
      endcase
      run_txn(m, ak, ab, 1'($urandom_range(0, 1)), NONE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
